// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Single-port memory arbiter for a fetch and a data requester,
//            data-first with fetch starvation guard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] c_LAT_LOAD   = 4'(MEM_LAT - 1);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_lat_cnt;
    logic [3:0]  r_starve_cnt;
    logic        r_gnt_d;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        w_grant;
    logic        w_pick_if;

    // Fetch only wins when data is idle or has starved fetch long enough.
    assign w_pick_if = if_req & (~d_req | (r_starve_cnt == c_STARVE_MAX));
    assign w_grant   = (r_state == ST_IDLE) & (if_req | d_req);

    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;
    assign stall    = (if_req & ~if_ack) | (d_req & ~d_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if_ack       = 1'b0;
        d_ack        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_req | d_req) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (r_lat_cnt == 4'd0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if_ack       = ~r_gnt_d;
                d_ack        = r_gnt_d;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_cnt    <= 4'd0;
            r_starve_cnt <= 4'd0;
            r_gnt_d      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_gnt_d   <= ~w_pick_if;
                r_lat_cnt <= c_LAT_LOAD;
                if (w_pick_if) begin
                    // Fetches are read-only, so write controls are forced low.
                    r_addr       <= if_addr;
                    r_we         <= 1'b0;
                    r_wdata      <= '0;
                    r_starve_cnt <= 4'd0;
                end else begin
                    r_addr  <= d_addr;
                    r_we    <= d_we;
                    r_wdata <= d_wdata;
                    if (if_req && (r_starve_cnt != c_STARVE_MAX)) begin
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
            end else if (r_state == ST_ACCESS) begin
                if (r_lat_cnt != 4'd0) begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                end else if (!r_gnt_d) begin
                    r_if_rdata <= mem_rdata;
                end else if (!r_we) begin
                    r_d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter (MEM_LAT=2, STARVE_MAX=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access to completion; cycle 1 is the first cycle after the grant edge.
    task automatic wait_ack(input bit want_d, output int cyc, output int en_cnt,
                            output int we_cnt, output int stall_cnt, output logic ack_stall,
                            output logic [31:0] seen_addr, output logic [31:0] seen_wdata);
        cyc = 0; en_cnt = 0; we_cnt = 0; stall_cnt = 0; ack_stall = 1'b1;
        seen_addr = 32'hFFFF_FFFF; seen_wdata = 32'hFFFF_FFFF;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (mem_en === 1'b1) begin
                en_cnt++;
                seen_addr  = mem_addr;
                seen_wdata = mem_wdata;
            end
            if (mem_we === 1'b1) we_cnt++;
            if ((want_d ? d_ack : if_ack) === 1'b1) begin
                cyc       = n;
                ack_stall = stall;
                break;
            end
            if (stall === 1'b1) stall_cnt++;
        end
        if (want_d) d_req = 1'b0;
        else        if_req = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({mem_en, mem_we, if_ack, d_ack, stall} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, if_ack, d_ack, stall});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h expected 0", {mem_addr, mem_wdata});
        end
        n_cmp++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
        end
    endtask

    task automatic test_load();
        int cyc, en, we, st; logic ast; logic [31:0] a, w;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; mem_rdata = 32'hCAFE_0001;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_stall_pending: got %b expected 1", stall); end
        wait_ack(1'b1, cyc, en, we, st, ast, a, w);
        n_cmp++;
        if (cyc !== 3) begin n_fail++; $display("FAIL load_ack_cycle: got %0d expected 3", cyc); end
        n_cmp++;
        if (en !== 2) begin n_fail++; $display("FAIL load_en_cycles: got %0d expected 2", en); end
        n_cmp++;
        if (a !== 32'h10) begin n_fail++; $display("FAIL load_addr: got %h expected 00000010", a); end
        n_cmp++;
        if (d_rdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL load_rdata: got %h expected cafe0001", d_rdata); end
        n_cmp++;
        if (st !== 2 || ast !== 1'b0) begin
            n_fail++; $display("FAIL load_stall: got %0d/%b expected 2/0", st, ast);
        end
        mem_rdata = 32'h0;
        tick();
        n_cmp++;
        if ({d_ack, stall, mem_en} !== 3'b0 || d_rdata !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL load_idle: got %b %h expected 000 cafe0001", {d_ack, stall, mem_en}, d_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int dcyc = 0, icyc = 0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; mem_rdata = 32'h1111_2222;
        #1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (d_ack === 1'b1) begin dcyc = n; d_req = 1'b0; mem_rdata = 32'h3333_4444; end
            if (if_ack === 1'b1) begin icyc = n; if_req = 1'b0; break; end
        end
        n_cmp++;
        if (dcyc !== 3) begin n_fail++; $display("FAIL simul_d_ack: got %0d expected 3", dcyc); end
        n_cmp++;
        if (icyc !== 7) begin n_fail++; $display("FAIL simul_if_ack: got %0d expected 7", icyc); end
        n_cmp++;
        if (d_rdata !== 32'h1111_2222 || if_rdata !== 32'h3333_4444) begin
            n_fail++; $display("FAIL simul_rdata: got %h/%h expected 11112222/33334444", d_rdata, if_rdata);
        end
        tick();
    endtask

    task automatic test_starve();
        logic kind [10];
        int k = 0, last = 0;
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; mem_rdata = 32'h5555_AAAA;
        for (int n = 1; n <= 80 && k < 10; n++) begin
            tick();
            if (d_ack === 1'b1) begin kind[k] = 1'b0; k++; last = n; end
            else if (if_ack === 1'b1) begin kind[k] = 1'b1; k++; last = n; end
        end
        if_req = 1'b0; d_req = 1'b0;
        n_cmp++;
        if (k !== 10 || last !== 39) begin
            n_fail++; $display("FAIL starve_count: got %0d acks last %0d expected 10 last 39", k, last);
        end
        for (int i = 0; i < k; i++) begin
            n_cmp++;
            if (kind[i] !== ((i == 4) || (i == 9))) begin
                n_fail++; $display("FAIL starve_order[%0d]: got fetch=%b expected fetch=%b", i, kind[i], (i == 4) || (i == 9));
            end
        end
        tick();
    endtask

    task automatic test_store();
        int cyc, en, we, st; logic ast; logic [31:0] a, w;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678; mem_rdata = 32'hDEAD_BEEF;
        wait_ack(1'b1, cyc, en, we, st, ast, a, w);
        n_cmp++;
        if (cyc !== 3 || we !== 2) begin n_fail++; $display("FAIL store_timing: got ack %0d we %0d expected 3/2", cyc, we); end
        n_cmp++;
        if (a !== 32'h20 || w !== 32'h1234_5678) begin
            n_fail++; $display("FAIL store_bus: got %h/%h expected 00000020/12345678", a, w);
        end
        n_cmp++;
        if (d_rdata !== 32'h5555_AAAA) begin n_fail++; $display("FAIL store_rdata_kept: got %h expected 5555aaaa", d_rdata); end
        tick();
        if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'h0BAD_F00D;
        wait_ack(1'b0, cyc, en, we, st, ast, a, w);
        n_cmp++;
        if (we !== 0 || cyc !== 3 || a !== 32'h300) begin
            n_fail++; $display("FAIL fetch_no_we: got we %0d ack %0d addr %h expected 0/3/00000300", we, cyc, a);
        end
        n_cmp++;
        if (if_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL fetch_rdata: got %h expected 0badf00d", if_rdata); end
        d_we = 1'b0; d_wdata = 32'h0;
        tick();
    endtask

    task automatic test_input_change();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; mem_rdata = 32'h77;
        tick();
        n_cmp++;
        if (mem_addr !== 32'h44 || mem_en !== 1'b1) begin
            n_fail++; $display("FAIL chg_grant: got en %b addr %h expected 1/00000044", mem_en, mem_addr);
        end
        d_req = 1'b0; d_addr = 32'h99; d_we = 1'b1;
        tick();
        n_cmp++;
        if (mem_addr !== 32'h44 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL chg_hold: got addr %h we %b expected 00000044/0", mem_addr, mem_we);
        end
        tick();
        n_cmp++;
        if (d_ack !== 1'b1 || d_rdata !== 32'h77) begin
            n_fail++; $display("FAIL chg_ack: got ack %b rdata %h expected 1/00000077", d_ack, d_rdata);
        end
        d_we = 1'b0; d_addr = 32'h0;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc, en, we, st; logic ast; logic [31:0] a, w;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60; mem_rdata = 32'hABCD_0123;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({mem_en, mem_we, d_ack, if_ack} !== 4'b0 || mem_addr !== 32'h0 || {d_rdata, if_rdata} !== 64'h0) begin
            n_fail++; $display("FAIL rstmid_async: got %b %h %h expected all 0", {mem_en, mem_we, d_ack, if_ack}, mem_addr, {d_rdata, if_rdata});
        end
        tick();
        tick();
        n_cmp++;
        if (d_ack !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_hold: got ack %b en %b expected 0/0", d_ack, mem_en);
        end
        rst = 1'b1;
        wait_ack(1'b1, cyc, en, we, st, ast, a, w);
        n_cmp++;
        if (cyc !== 3 || d_rdata !== 32'hABCD_0123) begin
            n_fail++; $display("FAIL rstmid_retry: got ack %0d rdata %h expected 3/abcd0123", cyc, d_rdata);
        end
        tick();
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        tick();
        tick();
        test_reset();
        rst = 1'b1;
        tick();
        test_load();
        test_simultaneous();
        test_starve();
        test_store();
        test_input_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 2, memory access latency in cycles (legal range 1..15).
REQ-002 Parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch request, held high until if_ack.
REQ-006 if_addr  input  32  fetch address, stable while if_req high.
REQ-007 if_rdata  output  32  fetched word, valid when if_ack high.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data-stage request, held high until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_rdata  output  32  load data, valid when d_ack high.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 mem_en  output  1  memory access enable.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_addr  output  32  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_rdata  input  32  memory read data, valid on the final ACCESS cycle.
REQ-020 stall  output  1  pipeline freeze request.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and RESP, and SHALL enter IDLE on reset.
REQ-022 In IDLE with any request, the block SHALL grant one requester at the clock edge and move to ACCESS.
REQ-023 On that grant it SHALL latch the requester's address, write enable and write data, and SHALL load the latency counter with MEM_LAT-1.
REQ-024 The data requester SHALL win by default; fetch SHALL win when only if_req is high, or when starve_cnt equals STARVE_MAX.
REQ-025 starve_cnt (4 bits) SHALL increment, saturating at STARVE_MAX, on each data grant made while if_req is high.
REQ-026 starve_cnt SHALL clear to 0 on every fetch grant.
REQ-027 In ACCESS, mem_en SHALL be 1 and mem_addr, mem_we and mem_wdata SHALL hold the latched values.
REQ-028 In ACCESS, the latency counter SHALL decrement each cycle; when it is 0, the FSM SHALL move to RESP and capture mem_rdata into the granted requester's rdata register.
REQ-029 mem_we SHALL be 1 only for a granted data store, and SHALL never be 1 for a fetch.
REQ-030 In IDLE and RESP, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-031 In RESP, the block SHALL pulse the granted requester's ack for exactly one cycle and return to IDLE.
REQ-032 Request-to-ack latency SHALL be MEM_LAT+1 cycles: grant at edge 0, ack high in cycle MEM_LAT+1.
REQ-033 A new grant MAY occur on the edge leaving IDLE, so back-to-back accesses SHALL cost MEM_LAT+2 cycles each.
REQ-034 if_rdata and d_rdata SHALL hold their last value until the next read completion for that port; stores SHALL NOT update d_rdata.
REQ-035 stall SHALL be combinational: (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-036 If a request deasserts after grant, the access SHALL still complete and its ack SHALL still pulse.
REQ-037 Changes to the requester inputs after grant SHALL NOT affect the access in progress.
REQ-038 If both requests arrive simultaneously, the non-granted one SHALL be served on the next arbitration unless it is deasserted.

Reset
REQ-039 Asserting rst low SHALL immediately force IDLE, starve_cnt=0, latency counter=0, and set every output (including both rdata registers) to 0.
REQ-040 A reset during ACCESS SHALL abandon the access with no ack; after release, pending requests SHALL be re-arbitrated from IDLE.

Verification
REQ-041 MEM_LAT=2, single load d_addr=0x10, mem returns 0xCAFE0001 -> mem_en high for 2 cycles, d_ack in cycle 3, d_rdata=0xCAFE0001.
REQ-042 if_req and d_req both high in the same cycle -> data granted first (d_ack in cycle 3), fetch granted next (if_ack in cycle 7).
REQ-043 if_req held high with continuous d_req, STARVE_MAX=4 -> four data acks, then one if_ack, then starve_cnt=0.
REQ-044 Store d_addr=0x20, d_wdata=0x12345678 -> mem_we=1 for 2 cycles with those values; d_rdata unchanged; if_req alone never raises mem_we.
REQ-045 rst pulsed low during ACCESS -> all outputs 0 at once, no ack; after release the held d_req completes in MEM_LAT+1 cycles.
REQ-046 stall check -> stall=1 every cycle a request is pending without ack, and 0 in ack cycles and when no request is pending.
